fir_result_reader: RTL and testbench

- Reads a contiguous block of filtered samples out of the FIR result BRAM and streams them to a downstream consumer over a valid/ready interface.
- It is the read-side counterpart of the pipelined FIR, which writes filtered samples into that BRAM.
- Hides the BRAM read latency and absorbs consumer backpressure with a small prefetch FIFO, so it sustains one sample per clock.

---
 rtl/fir_result_reader.sv | 164 ++++++++++++++++
 tb/tb_fir_result_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_result_reader.sv
// Streams a contiguous block of FIR results out of BRAM over valid/ready.
// A small prefetch FIFO hides the one-cycle BRAM latency and absorbs backpressure.
module fir_result_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic              bram_en_q, bram_en_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit;
  logic              credit_ok;

  assign push = rd_valid_q;
  assign pop  = m_valid && m_ready;

  // Every word already queued, returning, or just requested holds a FIFO slot.
  assign credit    = (CNT_W+1)'(count_q) + (CNT_W+1)'(rd_valid_q) + (CNT_W+1)'(bram_en_q);
  assign credit_ok = credit < (CNT_W+1)'(FIFO_DEPTH);

  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last    = m_valid && (out_cnt_q == (len_q - LEN_W'(1)));
  assign bram_en   = bram_en_q;
  assign bram_addr = bram_addr_q;
  assign busy      = (state_q == READ) || (state_q == DRAIN);
  assign done      = (state_q == FIN);

  always_comb begin
    state_d     = state_q;
    bram_en_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    rd_valid_d  = bram_en_q;
    len_d       = len_q;
    issued_d    = issued_q;
    out_cnt_d   = pop ? (out_cnt_q + LEN_W'(1)) : out_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            len_d       = length;
            bram_en_d   = 1'b1;
            bram_addr_d = base_addr;
            issued_d    = LEN_W'(1);
            out_cnt_d   = '0;
            state_d     = (length == LEN_W'(1)) ? DRAIN : READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          bram_en_d   = 1'b1;
          bram_addr_d = bram_addr_q + ADDR_W'(1);
          issued_d    = issued_q + LEN_W'(1);
          if ((issued_q + LEN_W'(1)) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      len_q       <= '0;
      issued_q    <= '0;
      out_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      rd_valid_q  <= rd_valid_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      out_cnt_q   <= out_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= bram_dout;
    end
  end

endmodule

// File: tb/tb_fir_result_reader.sv
// Directed self-checking bench for fir_result_reader against a behavioural 1-cycle BRAM.
module tb_fir_result_reader;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              done;

  int checks = 0;
  int passed = 0;

  logic [DATA_W-1:0] bram [1 << ADDR_W];

  int                got_addr[$];
  logic [DATA_W-1:0] got_data[$];
  logic              got_last[$];
  int                done_cnt;
  bit                timed_out;
  int                max_out;
  int                stalls;
  int                stall_bad;

  fir_result_reader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .bram_en(bram_en),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) bram_dout <= bram[bram_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int base, input int len);
    base_addr = ADDR_W'(base);
    length    = (ADDR_W+1)'(len);
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observes the block from the current cycle until done (or the budget expires).
  task automatic run_block(input int budget, input logic [3:0] pat);
    int issued;
    int popped;
    logic prev_stall;
    logic [DATA_W-1:0] prev_data;
    got_addr.delete();
    got_data.delete();
    got_last.delete();
    done_cnt = 0; timed_out = 1'b1; max_out = 0; stalls = 0; stall_bad = 0;
    issued = 0; popped = 0; prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < budget; i++) begin
      m_ready = pat[i % 4];
      if (bram_en) begin
        issued++;
        got_addr.push_back(int'(bram_addr));
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (prev_stall) begin
        stalls++;
        if (!m_valid || m_data !== prev_data) stall_bad++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        popped++;
        got_data.push_back(m_data);
        got_last.push_back(m_last);
      end
      if (done) begin
        done_cnt++;
        timed_out = 1'b0;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    tick(); tick();
    checks++; if (bram_en !== 1'b0) $display("[TB] FAIL reset_bram_en got %0b exp 0", bram_en); else passed++;
    checks++; if (bram_addr !== '0) $display("[TB] FAIL reset_bram_addr got %0d exp 0", bram_addr); else passed++;
    checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid got %0b exp 0", m_valid); else passed++;
    checks++; if (m_last !== 1'b0) $display("[TB] FAIL reset_m_last got %0b exp 0", m_last); else passed++;
    checks++; if (m_data !== '0) $display("[TB] FAIL reset_m_data got %0h exp 0", m_data); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %0b exp 0", done); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic exp_en, exp_valid;
    m_ready = 1'b1;
    issue_start(0, 5);
    for (int c = 1; c <= 9; c++) begin
      exp_en    = (c <= 5);
      exp_valid = (c >= 3 && c <= 7);
      checks++; if (bram_en !== exp_en) $display("[TB] FAIL basic_en c=%0d got %0b exp %0b", c, bram_en, exp_en); else passed++;
      if (exp_en) begin
        checks++; if (bram_addr !== ADDR_W'(c - 1)) $display("[TB] FAIL basic_addr c=%0d got %0d exp %0d", c, bram_addr, c - 1); else passed++;
      end
      checks++; if (m_valid !== exp_valid) $display("[TB] FAIL basic_valid c=%0d got %0b exp %0b", c, m_valid, exp_valid); else passed++;
      if (exp_valid) begin
        checks++; if (m_data !== DATA_W'((c - 3) * 3)) $display("[TB] FAIL basic_data c=%0d got %0d exp %0d", c, m_data, (c - 3) * 3); else passed++;
      end
      checks++; if (m_last !== (c == 7)) $display("[TB] FAIL basic_last c=%0d got %0b exp %0b", c, m_last, (c == 7)); else passed++;
      checks++; if (done !== (c == 8)) $display("[TB] FAIL basic_done c=%0d got %0b exp %0b", c, done, (c == 8)); else passed++;
      checks++; if (busy !== (c <= 7)) $display("[TB] FAIL basic_busy c=%0d got %0b exp %0b", c, busy, (c <= 7)); else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] got;
    m_ready = 1'b1;
    issue_start(40, 8);
    run_block(300, 4'b1001);
    checks++; if (timed_out) $display("[TB] FAIL bp_timeout got timed_out=1 exp 0"); else passed++;
    checks++; if (got_data.size() != 8) $display("[TB] FAIL bp_count got %0d exp 8", got_data.size()); else passed++;
    for (int k = 0; k < 8; k++) begin
      got = (k < got_data.size()) ? got_data[k] : 'x;
      checks++; if (got !== DATA_W'((40 + k) * 3)) $display("[TB] FAIL bp_data k=%0d got %0d exp %0d", k, got, (40 + k) * 3); else passed++;
    end
    checks++; if (max_out > FIFO_DEPTH) $display("[TB] FAIL bp_occupancy got %0d exp <= %0d", max_out, FIFO_DEPTH); else passed++;
    checks++; if (stalls == 0) $display("[TB] FAIL bp_stall_seen got 0 stalls exp > 0"); else passed++;
    checks++; if (stall_bad != 0) $display("[TB] FAIL bp_stall_stable got %0d unstable exp 0", stall_bad); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL bp_busy_after got %0b exp 0", busy); else passed++;
    m_ready = 1'b1;
  endtask

  task automatic test_wrap();
    int exp_addr[4];
    logic [DATA_W-1:0] exp_data[4];
    int ga;
    logic [DATA_W-1:0] gd;
    logic gl;
    exp_addr = '{1022, 1023, 0, 1};
    exp_data = '{32'd3066, 32'd3069, 32'd0, 32'd3};
    m_ready = 1'b1;
    issue_start(1022, 4);
    run_block(60, 4'b1111);
    checks++; if (done_cnt != 1) $display("[TB] FAIL wrap_done got %0d exp 1", done_cnt); else passed++;
    for (int k = 0; k < 4; k++) begin
      ga = (k < got_addr.size()) ? got_addr[k] : -1;
      gd = (k < got_data.size()) ? got_data[k] : 'x;
      gl = (k < got_last.size()) ? got_last[k] : 1'bx;
      checks++; if (ga != exp_addr[k]) $display("[TB] FAIL wrap_addr k=%0d got %0d exp %0d", k, ga, exp_addr[k]); else passed++;
      checks++; if (gd !== exp_data[k]) $display("[TB] FAIL wrap_data k=%0d got %0d exp %0d", k, gd, exp_data[k]); else passed++;
      checks++; if (gl !== (k == 3)) $display("[TB] FAIL wrap_last k=%0d got %0b exp %0b", k, gl, (k == 3)); else passed++;
    end
  endtask

  task automatic test_zero_length();
    m_ready = 1'b1;
    issue_start(5, 0);
    checks++; if (done !== 1'b1) $display("[TB] FAIL zero_done got %0b exp 1", done); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy got %0b exp 0", busy); else passed++;
    checks++; if (bram_en !== 1'b0) $display("[TB] FAIL zero_en1 got %0b exp 0", bram_en); else passed++;
    checks++; if (m_valid !== 1'b0) $display("[TB] FAIL zero_valid1 got %0b exp 0", m_valid); else passed++;
    tick();
    checks++; if (done !== 1'b0) $display("[TB] FAIL zero_done2 got %0b exp 0", done); else passed++;
    checks++; if (bram_en !== 1'b0) $display("[TB] FAIL zero_en2 got %0b exp 0", bram_en); else passed++;
    checks++; if (m_valid !== 1'b0) $display("[TB] FAIL zero_valid2 got %0b exp 0", m_valid); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_block();
    int hs;
    bit seen_done;
    logic [DATA_W-1:0] gd;
    logic gl;
    m_ready = 1'b1;
    issue_start(200, 10);
    hs = 0;
    for (int i = 0; i < 40 && hs < 3; i++) begin
      if (m_valid && m_ready) hs++;
      tick();
    end
    checks++; if (hs != 3) $display("[TB] FAIL rstmid_handshakes got %0d exp 3", hs); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (bram_en !== 1'b0) $display("[TB] FAIL rstmid_en got %0b exp 0", bram_en); else passed++;
    checks++; if (bram_addr !== '0) $display("[TB] FAIL rstmid_addr got %0d exp 0", bram_addr); else passed++;
    checks++; if (m_valid !== 1'b0) $display("[TB] FAIL rstmid_valid got %0b exp 0", m_valid); else passed++;
    checks++; if (m_data !== '0) $display("[TB] FAIL rstmid_data got %0h exp 0", m_data); else passed++;
    checks++; if (m_last !== 1'b0) $display("[TB] FAIL rstmid_last got %0b exp 0", m_last); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy got %0b exp 0", busy); else passed++;
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done || m_valid || bram_en) seen_done = 1'b1;
      tick();
    end
    checks++; if (seen_done) $display("[TB] FAIL rstmid_quiet got activity=1 exp 0"); else passed++;
    issue_start(100, 2);
    run_block(40, 4'b1111);
    checks++; if (done_cnt != 1) $display("[TB] FAIL rstmid_new_done got %0d exp 1", done_cnt); else passed++;
    checks++; if (got_data.size() != 2) $display("[TB] FAIL rstmid_new_count got %0d exp 2", got_data.size()); else passed++;
    for (int k = 0; k < 2; k++) begin
      gd = (k < got_data.size()) ? got_data[k] : 'x;
      gl = (k < got_last.size()) ? got_last[k] : 1'bx;
      checks++; if (gd !== DATA_W'((100 + k) * 3)) $display("[TB] FAIL rstmid_new_data k=%0d got %0d exp %0d", k, gd, (100 + k) * 3); else passed++;
      checks++; if (gl !== (k == 1)) $display("[TB] FAIL rstmid_new_last k=%0d got %0b exp %0b", k, gl, (k == 1)); else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    int ga;
    logic [DATA_W-1:0] gd;
    m_ready = 1'b1;
    issue_start(50, 6);
    tick();
    issue_start(500, 3);
    run_block(60, 4'b1111);
    checks++; if (done_cnt != 1) $display("[TB] FAIL busy_done got %0d exp 1", done_cnt); else passed++;
    checks++; if (got_data.size() != 6) $display("[TB] FAIL busy_count got %0d exp 6", got_data.size()); else passed++;
    checks++; if (got_addr.size() != 4) $display("[TB] FAIL busy_addr_count got %0d exp 4", got_addr.size()); else passed++;
    for (int k = 0; k < 4; k++) begin
      ga = (k < got_addr.size()) ? got_addr[k] : -1;
      checks++; if (ga != 52 + k) $display("[TB] FAIL busy_addr k=%0d got %0d exp %0d", k, ga, 52 + k); else passed++;
    end
    for (int k = 0; k < 6; k++) begin
      gd = (k < got_data.size()) ? got_data[k] : 'x;
      checks++; if (gd !== DATA_W'((50 + k) * 3)) $display("[TB] FAIL busy_data k=%0d got %0d exp %0d", k, gd, (50 + k) * 3); else passed++;
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL busy_idle_after got done=%0b busy=%0b exp 0/0", done, busy); else passed++;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      bram[i] = DATA_W'(i * 3);
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_length();
    test_reset_mid_block();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
